// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// No logic; consumed by bus_arbiter and rr_pick2.
// Owner IDs double as the registered read-data routing tag.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  localparam int unsigned MAX_BURST_DEFAULT = 16;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the non-last owner.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick2
  import bus_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic pick_vld,
  output logic pick_id
);

  // Tie-break favours whoever did not own the port last
  always_comb begin
    pick_vld = req0 | req1;
    pick_id  = OWNER_CPU;
    if (req0 && req1) begin
      pick_id = ~last_owner;
    end else if (req1) begin
      pick_id = OWNER_DMA;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates CPU (m0) and DMA (m1) beats onto one memory port with bounded bursts.
// Latency: one arbitration cycle before the first grant; read data returns one cycle after its grant.
// Backpressure: a requester waits with req high until gnt; a burst ends on req drop or after MAX_BURST beats.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_write_data,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_write_data,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_read_data,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_read_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned     CNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t       state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_tag_q, rd_tag_d;

  logic pick_vld;
  logic pick_id;
  logic gnt_any;
  logic sel_we;
  logic cur_owner;

  rr_pick2 u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_owner (last_owner_q),
    .pick_vld   (pick_vld),
    .pick_id    (pick_id)
  );

  // State register plus burst counter and the in-flight read tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_DMA;
      beat_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      rd_tag_q     <= OWNER_CPU;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  // Next state: arbitrate in IDLE, count beats while owned, release on req drop or burst limit
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    rd_pend_d    = gnt_any & ~sel_we;
    rd_tag_d     = gnt_any ? cur_owner : rd_tag_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = (pick_id == OWNER_DMA) ? OWN1 : OWN0;
        end
      end
      OWN0, OWN1: begin
        if (gnt_any && (beat_cnt_q != LAST_BEAT)) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end else begin
          // Either the owner went quiet or this beat completes the burst
          state_d      = IDLE;
          last_owner_d = cur_owner;
          beat_cnt_d   = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // Outputs: grant decode, memory port mux, and read-data routing by the registered tag
  always_comb begin
    cur_owner      = (state_q == OWN1) ? OWNER_DMA : OWNER_CPU;
    m0_gnt         = (state_q == OWN0) && m0_req;
    m1_gnt         = (state_q == OWN1) && m1_req;
    gnt_any        = m0_gnt | m1_gnt;
    sel_we         = m1_gnt ? m1_we : m0_we;
    mem_we         = gnt_any & sel_we;
    mem_addr       = '0;
    mem_write_data = '0;
    if (m0_gnt) begin
      mem_addr       = m0_addr;
      mem_write_data = m0_write_data;
    end else if (m1_gnt) begin
      mem_addr       = m1_addr;
      mem_write_data = m1_write_data;
    end
    m0_rvalid    = rd_pend_q && (rd_tag_q == OWNER_CPU);
    m1_rvalid    = rd_pend_q && (rd_tag_q == OWNER_DMA);
    m0_read_data = m0_rvalid ? mem_read_data : '0;
    m1_read_data = m1_rvalid ? mem_read_data : '0;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed stimulus for bus_arbiter (MAX_BURST=4) against a transaction-level model.
// Per cycle: drive inputs after the rising edge, compare every output at the falling edge.
// Memory behind the port is a small array with one-cycle registered read.
module tb_bus_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_write_data, m1_addr, m1_write_data;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_read_data, m1_read_data;
  logic        mem_we;
  logic [31:0] mem_addr, mem_write_data;
  logic [31:0] mem_read_data;

  bus_arbiter #(.MAX_BURST(MB)) dut (
    .clk            (clk),
    .rst            (rst),
    .m0_req         (m0_req),
    .m0_we          (m0_we),
    .m0_addr        (m0_addr),
    .m0_write_data  (m0_write_data),
    .m1_req         (m1_req),
    .m1_we          (m1_we),
    .m1_addr        (m1_addr),
    .m1_write_data  (m1_write_data),
    .m0_gnt         (m0_gnt),
    .m0_rvalid      (m0_rvalid),
    .m0_read_data   (m0_read_data),
    .m1_gnt         (m1_gnt),
    .m1_rvalid      (m1_rvalid),
    .m1_read_data   (m1_read_data),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [7:0] idx);
    return (idx == 8'd0) ? 32'h1234_5678 : {idx, ~idx, idx ^ 8'h5A, 8'hC3};
  endfunction

  // Memory behind the port: registered read, reloaded while reset is high
  logic [31:0] tb_mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(8'(i));
    end else if (mem_we) begin
      tb_mem[mem_addr[9:2]] <= mem_write_data;
    end
    mem_read_data <= tb_mem[mem_addr[9:2]];
  end

  // Transaction-level reference state
  logic [31:0] ref_mem [256];
  int          own;      // -1 none, else requester index
  int          last;
  int          beats;
  bit          pend;
  int          ptag;
  logic [31:0] pdat;
  bit          prev_g0, prev_g1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          g0_cnt, g1_cnt, we_cnt, rv1_cnt;
  int          order[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; last = 1; beats = 0; pend = 0; ptag = 0; pdat = '0;
    prev_g0 = 0; prev_g1 = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
  endtask

  task automatic clr_counts();
    g0_cnt = 0; g1_cnt = 0; we_cnt = 0; rv1_cnt = 0;
    order.delete();
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model
  task automatic cyc(input logic r, input logic q0, input logic w0, input logic [31:0] a0,
                     input logic [31:0] d0, input logic q1, input logic w1,
                     input logic [31:0] a1, input logic [31:0] d1);
    bit          g, wsel;
    logic [31:0] asel, dsel;
    logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
    bit          e_g0, e_g1, e_we, e_rv0, e_rv1;
    rst = r;
    m0_req = q0; m0_we = w0; m0_addr = a0; m0_write_data = d0;
    m1_req = q1; m1_we = w1; m1_addr = a1; m1_write_data = d1;
    @(negedge clk);
    if (r) begin
      g = 0; wsel = 0; asel = '0; dsel = '0;
      e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      g    = (own == 0 && q0) || (own == 1 && q1);
      wsel = (own == 1) ? w1 : w0;
      asel = (own == 1) ? a1 : a0;
      dsel = (own == 1) ? d1 : d0;
      e_g0 = g && own == 0;
      e_g1 = g && own == 1;
      e_rv0 = pend && ptag == 0;
      e_rv1 = pend && ptag == 1;
      e_rd0 = e_rv0 ? pdat : '0;
      e_rd1 = e_rv1 ? pdat : '0;
    end
    e_we   = g && wsel;
    e_addr = g ? asel : '0;
    e_wd   = g ? dsel : '0;
    chk("m0_gnt", 32'(m0_gnt), 32'(e_g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e_g1));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_write_data", mem_write_data, e_wd);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv1));
    chk("m0_read_data", m0_read_data, e_rd0);
    chk("m1_read_data", m1_read_data, e_rd1);
    if (m0_gnt) begin g0_cnt++; order.push_back(0); end
    if (m1_gnt) begin g1_cnt++; order.push_back(1); end
    if (mem_we) we_cnt++;
    if (m1_rvalid) rv1_cnt++;
    prev_g0 = e_g0; prev_g1 = e_g1;
    if (r) begin
      model_reset();
    end else begin
      pend = g && !wsel;
      if (pend) begin ptag = own; pdat = ref_mem[asel[9:2]]; end
      if (g && wsel) ref_mem[asel[9:2]] = dsel;
      if (own < 0) begin
        if (q0 && q1) own = (last == 0) ? 1 : 0;
        else if (q0)  own = 0;
        else if (q1)  own = 1;
      end else if (g) begin
        beats++;
        if (beats == MB) begin last = own; own = -1; beats = 0; end
      end else begin
        last = own; own = -1; beats = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input logic r);
    cyc(r, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    model_reset();
    clr_counts();

    // Reset values
    for (int i = 0; i < 3; i++) idle_cyc(1);
    idle_cyc(0);

    // Single read from IDLE: grant one cycle after req, data the cycle after
    clr_counts();
    cyc(0, 1, 0, 32'h4000, '0, 0, 0, '0, '0);
    cyc(0, 1, 0, 32'h4000, '0, 0, 0, '0, '0);
    cyc(0, 0, 0, '0, '0, 0, 0, '0, '0);
    chk("single_read_gnts", 32'(g0_cnt), 32'd1);
    idle_cyc(0);

    // Both rise together: m0 first, m0 drops after 3 beats, then m1 owns
    for (int i = 0; i < 2; i++) idle_cyc(1);
    clr_counts();
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 0, 32'h4000 + 32'(4*i), '0, 1, 0, 32'h4020, '0);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, '0, '0, 1, 0, 32'h4024, '0);
    chk("tie_m0_beats", 32'(g0_cnt), 32'd3);
    chk("tie_first_owner", 32'(order[0]), 32'd0);
    chk("tie_then_m1", 32'(order[order.size()-1]), 32'd1);
    idle_cyc(1);

    // m0 held continuously with m1 waiting: burst cut at MB beats, one idle, then m1
    clr_counts();
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 0, 32'h4000 + 32'(4*(i%8)), '0, 1, 0, 32'h4030, '0);
    chk("burst_m0_gnts", 32'(g0_cnt), 32'(MB));
    chk("burst_m1_after", 32'(g1_cnt), 32'd2);
    idle_cyc(1);

    // m1 single write: exactly one mem_we, no read valid
    clr_counts();
    cyc(0, 0, 0, '0, '0, 1, 1, 32'h4010, 32'hDEAD_BEEF);
    cyc(0, 0, 0, '0, '0, 1, 1, 32'h4010, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) idle_cyc(0);
    chk("write_we_cycles", 32'(we_cnt), 32'd1);
    chk("write_no_rvalid", 32'(rv1_cnt), 32'd0);
    // Read back the written word through m0
    cyc(0, 1, 0, 32'h4010, '0, 0, 0, '0, '0);
    cyc(0, 1, 0, 32'h4010, '0, 0, 0, '0, '0);
    idle_cyc(0);

    // Reset in the cycle after an m0 read grant suppresses the read return
    cyc(0, 1, 0, 32'h4000, '0, 0, 0, '0, '0);
    cyc(0, 1, 0, 32'h4000, '0, 0, 0, '0, '0);
    cyc(1, 1, 0, 32'h4000, '0, 0, 0, '0, '0);
    idle_cyc(0);
    idle_cyc(0);

    // Single-beat requesters that re-request right after each beat alternate fairly
    idle_cyc(1);
    clr_counts();
    for (int i = 0; i < 24; i++)
      cyc(0, !prev_g0, 0, 32'h4000 + 32'(4*(i%16)), '0,
             !prev_g1, 0, 32'h4040 + 32'(4*(i%16)), '0);
    chk("alt_grant_count", 32'(order.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < order.size(); i++)
      chk($sformatf("alt_order_%0d", i), 32'(order[i]), 32'(i % 2));

    // Randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      logic r, q0, q1, w0, w1;
      r  = ($urandom_range(0, 99) == 0);
      q0 = ($urandom_range(0, 3) != 0);
      q1 = ($urandom_range(0, 3) != 0);
      w0 = $urandom_range(0, 1) == 1;
      w1 = $urandom_range(0, 1) == 1;
      cyc(r, q0, w0, 32'h4000 + 32'(4*$urandom_range(0, 15)), $urandom,
             q1, w1, 32'h4000 + 32'(4*$urandom_range(0, 15)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
